// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: shifts per-pad GPIO configuration words into the two
// user-area serial configuration chains after a single xfer_start pulse.
// Pads go out highest index first, each word MSB first, so after the load
// strobe pad 0 ends up in the pad nearest the chain head.
// Optional feature macro: GPIO_LOADER_BITBANG_EN. When defined, bitbang_en
// routes the bb_* inputs straight (registered) onto the serial_* pins and
// aborts any transfer in flight. When undefined, bitbang_en and bb_* are
// ignored.
module gpio_serial_loader #(
    parameter int NUM_PADS = 19,
    parameter int WORD_W   = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        xfer_start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_PADS)-1:0] cfg_idx,
    input  logic [WORD_W-1:0]           cfg1_word,
    input  logic [WORD_W-1:0]           cfg2_word,
    input  logic                        bitbang_en,
    input  logic                        bb_clock,
    input  logic                        bb_load,
    input  logic                        bb_resetn,
    input  logic                        bb_data1,
    input  logic                        bb_data2,
    output logic                        serial_clock,
    output logic                        serial_load,
    output logic                        serial_resetn,
    output logic                        serial_data_1,
    output logic                        serial_data_2
);

    localparam int IDX_W = $clog2(NUM_PADS);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_PADS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shift1;
    logic [WORD_W-1:0] shift2;
    logic              div_last;
    logic              bb_active;

`ifdef GPIO_LOADER_BITBANG_EN
    assign bb_active = bitbang_en;
`else
    // Bypass is compiled out; bitbang_en is kept on the port list only.
    logic unused_bitbang_en;
    assign unused_bitbang_en = bitbang_en;
    assign bb_active = 1'b0;
`endif

    assign div_last = (div_cnt == DIV_LAST);

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic; bypass select forces the sequencer back to idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (xfer_start && !bb_active) next_state = FETCH;
            FETCH:    next_state = SHIFT_LO;
            SHIFT_LO: if (div_last) next_state = SHIFT_HI;
            SHIFT_HI: begin
                if (div_last) begin
                    if (bit_cnt != '0)      next_state = SHIFT_LO;
                    else if (cfg_idx != '0) next_state = FETCH;
                    else                    next_state = LOAD;
                end
            end
            LOAD:     if (div_last) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (bb_active && state != IDLE) next_state = IDLE;
    end

    // Half-period divider, bit counter, word shift registers and pad index.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shift1  <= '0;
            shift2  <= '0;
            cfg_idx <= '0;
        end else begin
            // Divider restarts on every state change so each phase is CLK_DIV long.
            if (state != next_state || state == IDLE) div_cnt <= '0;
            else                                      div_cnt <= div_cnt + 1'b1;

            if (state == FETCH) begin
                shift1  <= cfg1_word;
                shift2  <= cfg2_word;
                bit_cnt <= BIT_TOP;
            end else if (state == SHIFT_HI && next_state == SHIFT_LO) begin
                shift1  <= shift1 << 1;
                shift2  <= shift2 << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end

            if (state == IDLE && next_state == FETCH)
                cfg_idx <= IDX_TOP;
            else if (state == SHIFT_HI && next_state == FETCH)
                cfg_idx <= cfg_idx - 1'b1;
        end
    end

    // Registered pin drive and status; data only moves while serial_clock is low.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (bb_active) begin
                serial_clock  <= bb_clock;
                serial_load   <= bb_load;
                serial_resetn <= bb_resetn;
                serial_data_1 <= bb_data1;
                serial_data_2 <= bb_data2;
            end else begin
                serial_clock  <= (state == SHIFT_HI);
                serial_load   <= (state == LOAD);
                serial_resetn <= 1'b1;
                if (state == SHIFT_LO) begin
                    serial_data_1 <= shift1[WORD_W-1];
                    serial_data_2 <= shift2[WORD_W-1];
                end
            end
            busy <= (next_state != IDLE);
            done <= (state == DONE) && !bb_active;
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader. The stimulus side pushes the
// expected chain image for every transfer that should complete; a monitor
// models the two serial chains as bit queues clocked by serial_clock rising
// edges and checks them, plus timing, whenever done pulses.
// Define GPIO_LOADER_BITBANG_EN to also exercise the bypass path.
module tb_gpio_serial_loader;

    localparam int NP       = 19;
    localparam int WW       = 13;
    localparam int CD       = 2;
    localparam int NBITS    = NP * WW;
    localparam int BUSY_LEN = NP * (1 + 2 * CD * WW) + CD + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          xfer_start = 1'b0;
    logic          busy, done;
    logic [4:0]    cfg_idx;
    logic [WW-1:0] cfg1_word, cfg2_word;
    logic          bitbang_en = 1'b0;
    logic          bb_clock = 1'b0, bb_load = 1'b0, bb_resetn = 1'b0;
    logic          bb_data1 = 1'b0, bb_data2 = 1'b0;
    logic          serial_clock, serial_load, serial_resetn;
    logic          serial_data_1, serial_data_2;

    logic [WW-1:0] mem1 [NP];
    logic [WW-1:0] mem2 [NP];

    assign cfg1_word = (int'(cfg_idx) < NP) ? mem1[cfg_idx] : '0;
    assign cfg2_word = (int'(cfg_idx) < NP) ? mem2[cfg_idx] : '0;

    gpio_serial_loader #(.NUM_PADS(NP), .WORD_W(WW), .CLK_DIV(CD)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .xfer_start    (xfer_start),
        .busy          (busy),
        .done          (done),
        .cfg_idx       (cfg_idx),
        .cfg1_word     (cfg1_word),
        .cfg2_word     (cfg2_word),
        .bitbang_en    (bitbang_en),
        .bb_clock      (bb_clock),
        .bb_load       (bb_load),
        .bb_resetn     (bb_resetn),
        .bb_data1      (bb_data1),
        .bb_data2      (bb_data2),
        .serial_clock  (serial_clock),
        .serial_load   (serial_load),
        .serial_resetn (serial_resetn),
        .serial_data_1 (serial_data_1),
        .serial_data_2 (serial_data_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NP-1:0][WW-1:0] w1;
        logic [NP-1:0][WW-1:0] w2;
        int                    start;
    } exp_t;

    exp_t exp_q[$];
    bit   chain1[$];
    bit   chain2[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   exp_dones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: chain model plus per-transfer timing, checked on each done pulse.
    initial begin
        exp_t          e;
        bit            prev_clk, prev_busy, prev_d1, prev_d2;
        int            edges, loads, bcnt;
        logic [WW-1:0] g1, g2;
        prev_clk = 0; prev_busy = 0; prev_d1 = 0; prev_d2 = 0;
        edges = 0; loads = 0; bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_clk = 0;
                prev_busy = 0;
            end else begin
                if (busy && !prev_busy) begin
                    edges = 0; loads = 0; bcnt = 0;
                end
                if (busy) bcnt++;
                if (serial_load) loads++;
                if (serial_clock && !prev_clk) begin
                    edges++;
                    chain1.push_back(serial_data_1);
                    chain2.push_back(serial_data_2);
                    if (chain1.size() > NBITS) void'(chain1.pop_front());
                    if (chain2.size() > NBITS) void'(chain2.pop_front());
                end
                if (serial_clock && prev_clk && busy)
                    chk("data_hold", {30'd0, serial_data_2, serial_data_1}, {30'd0, prev_d2, prev_d1});
                if (done) begin
                    done_cnt++;
                    chk("done_busy_low", busy, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_latency", cyc - e.start, BUSY_LEN + 1);
                        chk("busy_len", bcnt, BUSY_LEN);
                        chk("clk_edges", edges, NBITS);
                        chk("load_cycles", loads, CD);
                        chk("chain_len", chain1.size(), NBITS);
                        if (chain1.size() == NBITS && chain2.size() == NBITS) begin
                            // Newest bit is nearest the head; pad p occupies head
                            // positions p*WW .. p*WW+WW-1 with its LSB closest.
                            for (int p = 0; p < NP; p++) begin
                                for (int b = 0; b < WW; b++) begin
                                    g1[b] = chain1[NBITS - 1 - (p * WW + b)];
                                    g2[b] = chain2[NBITS - 1 - (p * WW + b)];
                                end
                                chk($sformatf("chain1_pad%0d", p), g1, e.w1[p]);
                                chk($sformatf("chain2_pad%0d", p), g2, e.w2[p]);
                            end
                        end
                    end
                end
                prev_clk  = serial_clock;
                prev_busy = busy;
                prev_d1   = serial_data_1;
                prev_d2   = serial_data_2;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        xfer_start = 1'b1;
        @(posedge clk); #1;
        xfer_start = 1'b0;
    endtask

    // One full transfer of the current mem1/mem2 contents, optionally with a
    // second start pulse in the middle that must be ignored.
    task automatic run_xfer(input bit repulse);
        exp_t e;
        int   d0, n;
        for (int p = 0; p < NP; p++) begin
            e.w1[p] = mem1[p];
            e.w2[p] = mem2[p];
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        xfer_start = 1'b1;
        e.start = cyc;
        exp_q.push_back(e);
        exp_dones++;
        @(posedge clk); #1;
        xfer_start = 1'b0;
        if (repulse) begin
            repeat (498) @(posedge clk);
            #1 xfer_start = 1'b1;
            @(posedge clk); #1;
            xfer_start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 1500) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected one", n);
        end
        repeat (4) @(negedge clk);
        chk("idle_after", busy, 0);
    endtask

    task automatic fill_random();
        for (int p = 0; p < NP; p++) begin
            mem1[p] = WW'($urandom);
            mem2[p] = WW'($urandom);
        end
    endtask

    // Stimulus.
    initial begin
        bit saw;
        for (int p = 0; p < NP; p++) begin
            mem1[p] = '0;
            mem2[p] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_idx", cfg_idx, 0);
        chk("rst_sclk", serial_clock, 0);
        chk("rst_sload", serial_load, 0);
        chk("rst_sresetn", serial_resetn, 0);
        chk("rst_sdata", {serial_data_2, serial_data_1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("resetn_before_edge", serial_resetn, 0);
        @(negedge clk);
        chk("resetn_after_edge", serial_resetn, 1);

        saw = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) saw = 1;
        end
        chk("idle_no_busy", saw, 0);

        // All pads 0x1809 on both chains.
        for (int p = 0; p < NP; p++) begin
            mem1[p] = 13'h1809;
            mem2[p] = 13'h1809;
        end
        run_xfer(0);

        // Index-tagged words, plus an ignored start pulse mid-transfer.
        for (int p = 0; p < NP; p++) begin
            mem1[p] = WW'(13'h0400 + p);
            mem2[p] = WW'(13'h1000 + p);
        end
        run_xfer(1);

        fill_random();
        run_xfer(0);
        fill_random();
        run_xfer(0);

        // Asynchronous reset around bit 6 of pad 10.
        fill_random();
        pulse_start();
        repeat (448) @(posedge clk);
        #1;
        chk("abort_pad", cfg_idx, 10);
        rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_cfg_idx", cfg_idx, 0);
        chk("async_pins", {serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        fill_random();
        run_xfer(0);

`ifdef GPIO_LOADER_BITBANG_EN
        begin
            bit last_c, last_d;
            // Bypass: pins follow bb_* one cycle late, start is ignored.
            @(posedge clk); #1;
            bitbang_en = 1'b1;
            bb_resetn  = 1'b1;
            @(posedge clk); #1;
            last_c = bb_clock;
            last_d = bb_data1;
            xfer_start = 1'b1;
            for (int i = 0; i < 10; i++) begin
                bb_clock = ~bb_clock;
                bb_data1 = 1'($urandom);
                last_c = bb_clock;
                last_d = bb_data1;
                @(posedge clk); #1;
                xfer_start = 1'b0;
                chk("bb_clock_mirror", serial_clock, last_c);
                chk("bb_data_mirror", serial_data_1, last_d);
                chk("bb_no_busy", busy, 0);
            end
            bb_clock = 1'b0;
            bb_data1 = 1'b0;
            @(posedge clk); #1;
            bitbang_en = 1'b0;
            repeat (2) @(posedge clk);
            // Abort a transfer by raising bitbang_en.
            pulse_start();
            repeat (200) @(posedge clk);
            #1 bitbang_en = 1'b1;
            @(posedge clk); #1;
            chk("abort_busy", busy, 0);
            repeat (1100) @(posedge clk);
            #1 bitbang_en = 1'b0;
            repeat (2) @(posedge clk);
            fill_random();
            run_xfer(0);
        end
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, exp_dones);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
